sli_pattern_gen: RTL and testbench

SLI_PATTERN_GEN -- requirements
Module: sli_pattern_gen

---
 rtl/sli_pkg.sv | 30 +++
 rtl/sli_lut_ram.sv | 24 ++
 rtl/sli_pattern_gen.sv | 259 +++++++++++++++++++++++++
 tb/tb_sli_pattern_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sli_pkg.sv
// Shared types and defaults for the structured-light pattern generator.
// SLI_FLASH_EN adds a flash level after the last spatial frequency.
package sli_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_ARMED    = 2'd2,
    ST_EXPOSE   = 2'd3
  } sli_state_e;

  localparam int SLI_DATA_W   = 8;
  localparam int SLI_N_CH     = 3;
  localparam int SLI_LUT_AW   = 10;
  localparam int SLI_N_PHASE  = 8;
  localparam int SLI_N_FREQ   = 4;
  localparam int SLI_TRIG_CYC = 524288;
  localparam int SLI_POS_W    = 16;

`ifdef SLI_FLASH_EN
  localparam int SLI_FLV = 1;
`else
  localparam int SLI_FLV = 0;
`endif

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sli_lut_ram.sv
// Sinusoid LUT: one write port, one registered read port.
// Contents are never reset.
module sli_lut_ram
  import sli_pkg::*;
#(
  parameter int DW = SLI_DATA_W,
  parameter int AW = SLI_LUT_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sli_pattern_gen.sv
// Phase-shift fringe generator with camera trigger sequencing.
// Optional flash level enabled by defining SLI_FLASH_EN.
module sli_pattern_gen
  import sli_pkg::*;
#(
  parameter int DATA_W   = SLI_DATA_W,
  parameter int N_CH     = SLI_N_CH,
  parameter int LUT_AW   = SLI_LUT_AW,
  parameter int N_PHASE  = SLI_N_PHASE,
  parameter int N_FREQ   = SLI_N_FREQ,
  parameter int TRIG_CYC = SLI_TRIG_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*DATA_W-1:0]     in_pix,
  input  logic                       in_blank,
  input  logic                       in_hsync,
  input  logic                       in_vsync,
  output logic [N_CH*DATA_W-1:0]     out_pix,
  output logic                       out_blank,
  output logic                       out_hsync,
  output logic                       out_vsync,
  input  logic                       lut_we,
  input  logic [LUT_AW-1:0]          lut_addr,
  input  logic [DATA_W-1:0]          lut_data,
  input  logic                       mode,
  input  logic                       ori,
  input  logic [N_CH-1:0]            ch_en,
  input  logic                       rdy,
  output logic                       trig,
  output logic                       f_frm,
  output logic [clog2_min1(N_PHASE)-1:0]        fra,
  output logic [clog2_min1(N_FREQ+SLI_FLV)-1:0] frq
);

  localparam int PIX_W = N_CH * DATA_W;
  localparam int FA_W  = clog2_min1(N_PHASE);
  localparam int FQ_W  = clog2_min1(N_FREQ + SLI_FLV);
  localparam int TC_W  = clog2_min1(TRIG_CYC);
  localparam int PW    = (SLI_POS_W > LUT_AW) ? SLI_POS_W : LUT_AW;
  localparam int PH_SH = LUT_AW - $clog2(N_PHASE);

  localparam logic [FA_W-1:0] FA_MAX  = FA_W'(N_PHASE - 1);
  localparam logic [FQ_W-1:0] FQ_MAX  = FQ_W'(N_FREQ - 1 + SLI_FLV);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TRIG_CYC - 1);

  sli_state_e st_q, st_d;

  logic vs_q, hs_q, rdy_q;
  logic vs_rise, hs_rise, rdy_rise;

  logic [PW-1:0] col_q, col_d;
  logic [PW-1:0] row_q, row_d;
  logic [PW-1:0] pos;
  logic          lact_q, lact_d;

  logic [FA_W-1:0] fra_q, fra_d;
  logic [FQ_W-1:0] frq_q, frq_d;
  logic [TC_W-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            ori_q, ori_d;

  logic [LUT_AW-1:0] rd_addr;
  logic [DATA_W-1:0] lut_rd;

  logic [PIX_W-1:0] pix1_q, opix_q, pix_d;
  logic             blk1_q, hs1_q, vs1_q;
  logic             oblk_q, ohs_q, ovs_q;
  logic             pat1_q;
  logic [N_CH-1:0]  en1_q;
`ifdef SLI_FLASH_EN
  logic             fl1_q, flv1_q;
`endif

  assign vs_rise  = in_vsync & ~vs_q;
  assign hs_rise  = in_hsync & ~hs_q;
  assign rdy_rise = rdy & ~rdy_q;

  // Raster position: col restarts at hsync, row advances after each active line.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    lact_d = lact_q;
    if (vs_rise) begin
      col_d  = '0;
      row_d  = '0;
      lact_d = 1'b0;
    end else if (hs_rise) begin
      col_d  = '0;
      lact_d = 1'b0;
      if (lact_q && !(&row_q)) row_d = row_q + 1'b1;
    end else if (!in_blank) begin
      lact_d = 1'b1;
      if (!(&col_q)) col_d = col_q + 1'b1;
    end
  end

  assign pos     = ori ? col_q : row_q;
  assign rd_addr = LUT_AW'((pos << frq_q) + (PW'(fra_q) << PH_SH));

  always_comb begin
    st_d   = st_q;
    fra_d  = fra_q;
    frq_d  = frq_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ori_d  = ori_q;
    case (st_q)
      ST_IDLE: begin
        if (vs_rise && mode) st_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (rdy_rise || pend_q) begin
          st_d   = ST_ARMED;
          pend_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (vs_rise) begin
          st_d  = ST_EXPOSE;
          cnt_d = '0;
          if (fra_q == FA_MAX) begin
            fra_d = '0;
            frq_d = (frq_q == FQ_MAX) ? '0 : frq_q + 1'b1;
          end else begin
            fra_d = fra_q + 1'b1;
          end
        end
      end
      ST_EXPOSE: begin
        if (rdy_rise) pend_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TC_LAST) st_d = ST_WAIT_RDY;
      end
      default: st_d = ST_IDLE;
    endcase
    // Mode and orientation changes at frame start override the sequence.
    if (vs_rise) begin
      ori_d = ori;
      if (!mode) begin
        st_d   = ST_IDLE;
        fra_d  = '0;
        frq_d  = '0;
        pend_d = 1'b0;
      end else if (ori != ori_q) begin
        st_d   = ST_WAIT_RDY;
        fra_d  = '0;
        frq_d  = '0;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      rdy_q  <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      lact_q <= 1'b0;
      fra_q  <= '0;
      frq_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ori_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      vs_q   <= in_vsync;
      hs_q   <= in_hsync;
      rdy_q  <= rdy;
      col_q  <= col_d;
      row_q  <= row_d;
      lact_q <= lact_d;
      fra_q  <= fra_d;
      frq_q  <= frq_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ori_q  <= ori_d;
    end
  end

  sli_lut_ram #(
    .DW(DATA_W),
    .AW(LUT_AW)
  ) u_lut (
    .clk    (clk),
    .we_i   (lut_we),
    .waddr_i(lut_addr),
    .wdata_i(lut_data),
    .raddr_i(rd_addr),
    .rdata_o(lut_rd)
  );

  // Stage 1 aligns video and controls with the registered LUT read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix1_q <= '0;
      blk1_q <= 1'b1;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      pat1_q <= 1'b0;
      en1_q  <= '0;
`ifdef SLI_FLASH_EN
      fl1_q  <= 1'b0;
      flv1_q <= 1'b0;
`endif
    end else begin
      pix1_q <= in_pix;
      blk1_q <= in_blank;
      hs1_q  <= in_hsync;
      vs1_q  <= in_vsync;
      pat1_q <= (st_q != ST_IDLE);
      en1_q  <= ch_en;
`ifdef SLI_FLASH_EN
      fl1_q  <= (frq_q == FQ_W'(N_FREQ));
      flv1_q <= fra_q[0];
`endif
    end
  end

  always_comb begin
    pix_d = pix1_q;
    if (!blk1_q && pat1_q) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!en1_q[c]) pix_d[c*DATA_W +: DATA_W] = '0;
`ifdef SLI_FLASH_EN
        else if (fl1_q) pix_d[c*DATA_W +: DATA_W] = {DATA_W{flv1_q}};
`endif
        else pix_d[c*DATA_W +: DATA_W] = lut_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opix_q <= '0;
      oblk_q <= 1'b1;
      ohs_q  <= 1'b0;
      ovs_q  <= 1'b0;
    end else begin
      opix_q <= pix_d;
      oblk_q <= blk1_q;
      ohs_q  <= hs1_q;
      ovs_q  <= vs1_q;
    end
  end

  assign out_pix   = opix_q;
  assign out_blank = oblk_q;
  assign out_hsync = ohs_q;
  assign out_vsync = ovs_q;
  assign trig      = (st_q == ST_EXPOSE);
  assign f_frm     = (fra_q == '0) && (frq_q == '0);
  assign fra       = fra_q;
  assign frq       = frq_q;

endmodule

// File: tb/tb_sli_pattern_gen.sv
// Directed bench for sli_pattern_gen: video scoreboard plus
// trigger/index sequencing checks on small frames.
module tb_sli_pattern_gen;

  localparam int DW  = 8;
  localparam int NC  = 3;
  localparam int AW  = 10;
  localparam int NP  = 8;
  localparam int NF  = 4;
  localparam int TC  = 16;
  localparam int PXW = DW * NC;
  localparam int VW  = PXW + 3;
  localparam int HA  = 8;
  localparam int HT  = 12;
  localparam int VB  = 2;
  localparam int VA  = 8;
  localparam int VT  = VB + VA;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [PXW-1:0] in_pix = '0;
  logic           in_blank = 1'b1;
  logic           in_hsync = 1'b0;
  logic           in_vsync = 1'b0;
  logic [PXW-1:0] out_pix;
  logic           out_blank, out_hsync, out_vsync;
  logic           lut_we = 1'b0;
  logic [AW-1:0]  lut_addr = '0;
  logic [DW-1:0]  lut_data = '0;
  logic           mode = 1'b0;
  logic           ori = 1'b0;
  logic [NC-1:0]  ch_en = 3'b111;
  logic           rdy = 1'b0;
  logic           trig, f_frm;
  logic [2:0]     fra;
  logic [1:0]     frq;

  sli_pattern_gen #(
    .DATA_W(DW), .N_CH(NC), .LUT_AW(AW),
    .N_PHASE(NP), .N_FREQ(NF), .TRIG_CYC(TC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_pix(in_pix), .in_blank(in_blank),
    .in_hsync(in_hsync), .in_vsync(in_vsync),
    .out_pix(out_pix), .out_blank(out_blank),
    .out_hsync(out_hsync), .out_vsync(out_vsync),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .mode(mode), .ori(ori), .ch_en(ch_en), .rdy(rdy),
    .trig(trig), .f_frm(f_frm), .fra(fra), .frq(frq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int trig_cnt = 0;
  int m_fra = 0;
  int m_frq = 0;
  bit m_pat = 1'b0;
  logic [VW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    m_fra++;
    if (m_fra == NP) begin
      m_fra = 0;
      m_frq = (m_frq == NF - 1) ? 0 : m_frq + 1;
    end
  endtask

  function automatic logic [VW-1:0] expv(input logic [PXW-1:0] px,
      input logic blk, input logic hs, input logic vs,
      input int row, input int col);
    logic [PXW-1:0] o;
    int a;
    o = px;
    if (!blk && m_pat) begin
      a = ((((ori ? col : row) << m_frq) + m_fra * ((2**AW) / NP))) % (2**AW);
      for (int c = 0; c < NC; c++)
        o[c*DW +: DW] = ch_en[c] ? DW'(a) : '0;
    end
    return {o, blk, hs, vs};
  endfunction

  // One pixel: push expectation, check the output of two pixels ago.
  task automatic tick(input logic [VW-1:0] e);
    logic [VW-1:0] x;
    sb.push_back(e);
    @(negedge clk);
    if (trig) trig_cnt++;
    if (sb.size() >= 3) begin
      x = sb.pop_front();
      chk("pipe", 32'({out_pix, out_blank, out_hsync, out_vsync}), 32'(x));
    end
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = no index change, 1 = advance, 2 = zero (ori change)
  task automatic frame(input int kind, input int ra, input int rb);
    int idx;
    logic act;
    trig_cnt = 0;
    for (int l = 0; l < VT; l++) begin
      for (int p = 0; p < HT; p++) begin
        idx = l * HT + p;
        act = (l >= VB) && (p < HA);
        in_pix   = PXW'($urandom);
        in_blank = !act;
        in_vsync = (l == 0);
        in_hsync = (p == HA + 1) || (p == HA + 2);
        rdy      = (idx == ra) || (idx == rb);
        if (idx == 0) begin
          m_pat = mode;
          if (!mode || kind == 2) begin
            m_fra = 0;
            m_frq = 0;
          end else if (kind == 1) begin
            adv();
          end
        end
        tick(expv(in_pix, in_blank, in_hsync, in_vsync, l - VB, p));
      end
    end
    rdy = 1'b0;
  endtask

  task automatic chk_idx(input string tag);
    chk({tag, "_fra"}, 32'(fra), 32'(m_fra));
    chk({tag, "_frq"}, 32'(frq), 32'(m_frq));
    chk({tag, "_ffrm"}, 32'(f_frm), 32'((m_fra == 0) && (m_frq == 0)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix", 32'(out_pix), 32'(0));
    chk("rst_blank", 32'(out_blank), 32'(1));
    chk("rst_hs", 32'(out_hsync), 32'(0));
    chk("rst_vs", 32'(out_vsync), 32'(0));
    chk("rst_trig", 32'(trig), 32'(0));
    chk("rst_fra", 32'(fra), 32'(0));
    chk("rst_frq", 32'(frq), 32'(0));
    chk("rst_ffrm", 32'(f_frm), 32'(1));
    rst = 1'b0;

    for (int a = 0; a < 2**AW; a++) begin
      lut_we   = 1'b1;
      lut_addr = AW'(a);
      lut_data = DW'(a);
      @(posedge clk);
      #1;
    end
    lut_we = 1'b0;
    sb.delete();

    mode = 1'b0;
    frame(0, -1, -1);
    chk("pt_trig", 32'(trig_cnt), 32'(0));
    frame(0, 30, -1);
    chk("pt_trig2", 32'(trig_cnt), 32'(0));
    chk_idx("pt");

    mode = 1'b1;
    frame(0, -1, -1);
    chk("pat_trig", 32'(trig_cnt), 32'(0));
    ch_en = 3'b100;
    frame(0, -1, -1);
    ch_en = 3'b111;

    frame(0, 60, -1);
    chk("arm_fra", 32'(fra), 32'(0));
    chk("arm_trig", 32'(trig_cnt), 32'(0));
    frame(1, 60, -1);
    chk("trig_len", 32'(trig_cnt), 32'(TC));
    chk("adv_fra", 32'(fra), 32'(1));

    for (int i = 0; i < 31; i++) begin
      frame(1, (i == 30) ? -1 : 60, -1);
      chk("seq_trig", 32'(trig_cnt), 32'(TC));
      chk_idx("seq");
      if (i == 6) begin
        chk("wrap_fra", 32'(fra), 32'(0));
        chk("wrap_frq", 32'(frq), 32'(1));
        chk("wrap_ffrm", 32'(f_frm), 32'(0));
      end
    end
    chk("full_ffrm", 32'(f_frm), 32'(1));

    frame(0, 60, -1);
    frame(1, 3, 8);
    chk("pend_trig", 32'(trig_cnt), 32'(TC));
    chk("pend_fra1", 32'(fra), 32'(1));
    frame(1, -1, -1);
    chk("pend_trig2", 32'(trig_cnt), 32'(TC));
    chk("pend_fra2", 32'(fra), 32'(2));
    frame(0, -1, -1);
    chk("pend_once", 32'(fra), 32'(2));
    chk("pend_idle", 32'(trig_cnt), 32'(0));

    frame(0, 60, -1);
    ori = 1'b1;
    frame(2, -1, -1);
    chk("ori_trig", 32'(trig_cnt), 32'(0));
    chk_idx("ori");

    frame(0, 60, -1);
    in_blank = 1'b1;
    in_hsync = 1'b0;
    in_vsync = 1'b1;
    rdy      = 1'b0;
    m_pat    = 1'b1;
    adv();
    for (int k = 0; k < 4; k++) begin
      in_pix = PXW'($urandom);
      tick(expv(in_pix, 1'b1, 1'b0, 1'b1, 0, 0));
    end
    chk("exp_on", 32'(trig), 32'(1));
    chk("exp_fra", 32'(fra), 32'(1));
    rst      = 1'b1;
    in_vsync = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_trig", 32'(trig), 32'(0));
    chk("mrst_fra", 32'(fra), 32'(0));
    chk("mrst_frq", 32'(frq), 32'(0));
    chk("mrst_blank", 32'(out_blank), 32'(1));
    chk("mrst_pix", 32'(out_pix), 32'(0));
    m_fra = 0;
    m_frq = 0;
    m_pat = 1'b0;
    sb.delete();

    frame(0, -1, -1);
    chk_idx("post");
    mode = 1'b0;
    frame(0, -1, -1);
    chk("end_trig", 32'(trig_cnt), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
